// File: rtl/jmp_br_jalr_mux.sv
// -----------------------------------------------------------------------------
// jmp_br_jalr_mux
//
// Purpose:
//    Next-PC target select for the RV32 fetch stage. Chooses between the
//    branch/JAL target and the JALR target, then forwards the result to the
//    PC-source mux. This is a purely combinational 2:1 datapath mux with
//    zero-cycle latency. The clock and reset ports exist only so that every
//    core module has the same interface. No state is held.
//
// Parameters:
//    XLEN          datapath width of both targets and of the output
//    JALR_CLR_LSB  1: force bit 0 of the JALR path to 0 (RISC-V JALR rule)
//                  0: pass the JALR target through unchanged
//
// Ports:
//    clock                   in   1     core clock (not used by any logic)
//    reset                   in   1     async active-high reset (no state)
//    io_br_jmp               in   XLEN  branch / JAL target (PC + imm)
//    io_jalr                 in   XLEN  JALR target (rs1 + imm)
//    io_jmp_br_jalr_mux_sel  in   1     0: io_br_jmp, 1: JALR path
//    io_to_pc_mux            out  XLEN  selected target, to PC-source mux
// -----------------------------------------------------------------------------
module jmp_br_jalr_mux #(
   parameter int unsigned XLEN         = 32,
   parameter bit          JALR_CLR_LSB = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] io_br_jmp,
   input  logic [XLEN-1:0] io_jalr,
   input  logic            io_jmp_br_jalr_mux_sel,
   output logic [XLEN-1:0] io_to_pc_mux
);

   logic [XLEN-1:0] jalr_path;

   // When the LSB is cleared, the JALR target loses bit 0. The branch/JAL path
   // is never changed: this module does no alignment checks and raises no
   // exceptions.
   generate
      if (JALR_CLR_LSB) begin : g_jalr_clr
         assign jalr_path = {io_jalr[XLEN-1:1], 1'b0};
      end else begin : g_jalr_pass
         assign jalr_path = io_jalr;
      end
   endgenerate

   // The output depends only on the inputs. Reset does not affect it, so the
   // output keeps tracking the inputs while reset is asserted, and a reset
   // edge cannot cause a glitch of its own.
   always_comb begin
      // NOTE: assign the default first so that every path drives the output;
      // a branch that leaves the output unassigned would infer a latch.
      io_to_pc_mux = io_br_jmp;
      if (io_jmp_br_jalr_mux_sel) begin
         io_to_pc_mux = jalr_path;
      end
   end

   // Interface-only inputs (and the JALR bit that is dropped when the LSB is
   // cleared) are collected here, so that they are visibly intentional.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clock, reset, io_jalr[0]};

endmodule

// File: tb/tb_jmp_br_jalr_mux.sv
// -----------------------------------------------------------------------------
// tb_jmp_br_jalr_mux
//
// Self-checking bench for jmp_br_jalr_mux. It instantiates the mux twice, once
// with the JALR LSB passed through and once with it cleared. Both instances
// share the same stimulus. Each output is compared with a behavioural model
// that computes the expected next-PC target directly from the selection rule.
// -----------------------------------------------------------------------------
module tb_jmp_br_jalr_mux;

   localparam int unsigned XLEN = 32;

   logic            clock;
   logic            reset;
   logic [XLEN-1:0] io_br_jmp;
   logic [XLEN-1:0] io_jalr;
   logic            io_jmp_br_jalr_mux_sel;
   logic [XLEN-1:0] out_pass;
   logic [XLEN-1:0] out_clr;

   int assert_count = 0;
   int fail_count   = 0;

   jmp_br_jalr_mux #(.XLEN(XLEN), .JALR_CLR_LSB(1'b0)) u_dut_pass (
      .clock                  (clock),
      .reset                  (reset),
      .io_br_jmp              (io_br_jmp),
      .io_jalr                (io_jalr),
      .io_jmp_br_jalr_mux_sel (io_jmp_br_jalr_mux_sel),
      .io_to_pc_mux           (out_pass)
   );

   jmp_br_jalr_mux #(.XLEN(XLEN), .JALR_CLR_LSB(1'b1)) u_dut_clr (
      .clock                  (clock),
      .reset                  (reset),
      .io_br_jmp              (io_br_jmp),
      .io_jalr                (io_jalr),
      .io_jmp_br_jalr_mux_sel (io_jmp_br_jalr_mux_sel),
      .io_to_pc_mux           (out_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model. A jump through a register lands on an even address
   // when clearing is enabled; otherwise the chosen target is used as-is.
   function automatic logic [XLEN-1:0] model(input logic sel, input logic [XLEN-1:0] br,
                                             input logic [XLEN-1:0] jalr, input bit clr_lsb);
      longint unsigned target;
      if (!sel) return br;
      target = longint'(jalr);
      if (clr_lsb) target = target - (target % 2);
      return target[XLEN-1:0];
   endfunction

   task automatic check(input string tag, input logic [XLEN-1:0] observed,
                        input logic [XLEN-1:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic check_both(input string tag);
      check({tag, "/pass"}, out_pass,
            model(io_jmp_br_jalr_mux_sel, io_br_jmp, io_jalr, 1'b0));
      check({tag, "/clr"}, out_clr,
            model(io_jmp_br_jalr_mux_sel, io_br_jmp, io_jalr, 1'b1));
   endtask

   // Drive the inputs between clock edges and sample 1 ns later. No clock
   // edge falls between driving and sampling.
   task automatic apply(input logic sel, input logic [XLEN-1:0] br, input logic [XLEN-1:0] jalr);
      io_jmp_br_jalr_mux_sel = sel;
      io_br_jmp              = br;
      io_jalr                = jalr;
      #1;
   endtask

   initial begin
      reset                  = 1'b1;
      io_jmp_br_jalr_mux_sel = 1'b0;
      io_br_jmp              = '0;
      io_jalr                = '0;
      #2;
      // While reset is asserted, the output follows the inputs.
      check("reset_zero_pass", out_pass, 32'h0000_0000);
      check("reset_zero_clr",  out_clr,  32'h0000_0000);
      apply(1'b1, 32'h0000_0000, 32'h0000_0007);
      check("reset_track_pass", out_pass, 32'h0000_0007);
      check("reset_track_clr",  out_clr,  32'h0000_0006);
      reset = 1'b0;

      @(posedge clock); #2;
      apply(1'b0, 32'h1234_5678, 32'hDEAD_BEEF);
      check("sel0_pass", out_pass, 32'h1234_5678);
      check("sel0_clr",  out_clr,  32'h1234_5678);
      apply(1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
      check("sel1_pass", out_pass, 32'hDEAD_BEEF);
      check("sel1_clr",  out_clr,  32'hDEAD_BEEE);

      // With sel held at 1, the output follows the JALR target without a clock edge.
      apply(1'b1, 32'h1234_5678, 32'h0000_0000);
      check("jalr_zero_pass", out_pass, 32'h0000_0000);
      check("jalr_zero_clr",  out_clr,  32'h0000_0000);
      apply(1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
      check("jalr_ones_pass", out_pass, 32'hFFFF_FFFF);
      check("jalr_ones_clr",  out_clr,  32'hFFFF_FFFE);

      // A reset asserted and released mid-operation leaves the output unchanged.
      @(posedge clock); #2;
      apply(1'b0, 32'h8000_0004, 32'h5555_5555);
      reset = 1'b1;
      #1;
      check("mid_reset_on_pass", out_pass, 32'h8000_0004);
      check("mid_reset_on_clr",  out_clr,  32'h8000_0004);
      @(posedge clock); #2;
      check("mid_reset_hold_pass", out_pass, 32'h8000_0004);
      reset = 1'b0;
      #1;
      check("mid_reset_off_pass", out_pass, 32'h8000_0004);
      check("mid_reset_off_clr",  out_clr,  32'h8000_0004);

      // Boundary: with sel=0, an all-ones branch target keeps every bit,
      // including bit 0, even in the instance that clears the JALR LSB.
      apply(1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
      check("br_ones_pass", out_pass, 32'hFFFF_FFFF);
      check("br_ones_clr",  out_clr,  32'hFFFF_FFFF);
      apply(1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
      check("br_odd_clr", out_clr, 32'h0000_0001);

      // sel toggles once per clock period, with random targets.
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #2;
         apply(i[0], $urandom, $urandom);
         check_both($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
